// File: rtl/forth_data_stack.sv
// forth_data_stack: T register plus DEPTH-entry data stack feeding the ALU T/D operands.
// Ports: clk, rst (sync, active-high); op (000 NOP, 001 PUSH, 010 DROP, 011 LOAD,
//   100 NIPLD, 101 SWAP, 11x NOP); din ALU result; flag_in/flag_we ALU borrow capture;
//   err_clr clears sticky err; tos/nos ALU operands; flag; depth/empty/full; err.
// Option: FORTH_DSTACK_ERR_EN enables the sticky err register; otherwise err is 0.
module forth_data_stack #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2:0]                 op,
  input  logic [WIDTH-1:0]           din,
  input  logic                       flag_in,
  input  logic                       flag_we,
  input  logic                       err_clr,
  output logic [WIDTH-1:0]           tos,
  output logic [WIDTH-1:0]           nos,
  output logic                       flag,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       empty,
  output logic                       full,
  output logic                       err
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] OP_PUSH = 3'b001;
  localparam logic [2:0] OP_DROP = 3'b010;
  localparam logic [2:0] OP_LOAD = 3'b011;
  localparam logic [2:0] OP_NIPLD = 3'b100;
  localparam logic [2:0] OP_SWAP = 3'b101;
  logic [WIDTH-1:0] t_q, t_d, n_w;
  logic [WIDTH-1:0] stk_q [DEPTH];
  logic [DW-1:0] dep_q, dep_d;
  logic [AW-1:0] wr_idx, top_idx;
  logic flag_q, flag_d, is_empty, is_full, pop_op, ovf, unf, do_push, do_swap, do_dec;
  always_comb begin
    is_empty = dep_q == '0;
    is_full = dep_q == DW'(DEPTH);
    wr_idx = AW'(dep_q);
    top_idx = AW'(dep_q - DW'(1));
    n_w = is_empty ? '0 : stk_q[top_idx];
    pop_op = op == OP_DROP || op == OP_NIPLD || op == OP_SWAP;
    ovf = op == OP_PUSH && is_full;
    unf = pop_op && is_empty;
    do_push = op == OP_PUSH && !is_full;
    do_swap = op == OP_SWAP && !is_empty;
    do_dec = (op == OP_DROP || op == OP_NIPLD) && !is_empty;
    t_d = do_push || op == OP_LOAD || (op == OP_NIPLD && !is_empty) ? din
        : (op == OP_DROP && !is_empty) || do_swap ? n_w : t_q;
    dep_d = do_push ? dep_q + DW'(1) : do_dec ? dep_q - DW'(1) : dep_q;
    flag_d = flag_we ? flag_in : flag_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      t_q <= '0;
      dep_q <= '0;
      flag_q <= 1'b0;
    end else begin
      t_q <= t_d;
      dep_q <= dep_d;
      flag_q <= flag_d;
    end
  end
  // Stack cells need no reset: nos masks them to 0 whenever depth is 0.
  always_ff @(posedge clk) begin
    if (!rst && do_push) stk_q[wr_idx] <= t_q;
    else if (!rst && do_swap) stk_q[top_idx] <= t_q;
  end
`ifdef FORTH_DSTACK_ERR_EN
  logic err_q, err_d;
  // A fresh error beats a simultaneous clear.
  assign err_d = ovf || unf ? 1'b1 : err_clr ? 1'b0 : err_q;
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else err_q <= err_d;
  end
  assign err = err_q;
`else
  logic err_unused;
  assign err_unused = err_clr ^ ovf ^ unf;
  assign err = 1'b0;
`endif
  assign tos = t_q;
  assign nos = n_w;
  assign flag = flag_q;
  assign depth = dep_q;
  assign empty = is_empty;
  assign full = is_full;
endmodule
